fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front-end that sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready request and response interface.
- Buffers returned instructions with their PCs in a small FIFO, then presents one {pc, instr} pair per cycle to decode.
- Honours decode stalls (hazard unit) and branch redirects from the ID-stage comparator, discarding wrong-path responses exactly.

Parameters:
- XLEN, 64, PC and address width.
- DEPTH, 4, instruction FIFO entries (power of two, ≥2).
- MAX_OUTSTANDING, 2, maximum memory requests in flight (≤DEPTH).
- RESET_PC, 64'h0, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_addr  out  XLEN  word address {2'b00, pc[XLEN-1:2]}.
- imem_rsp_valid  in  1  response valid; responses return in request order.
- imem_rsp_data  in  32  instruction word.
- stall  in  1  decode cannot accept; hold the output.
- redirect_valid  in  1  taken branch resolved in ID.
- redirect_pc  in  XLEN  branch target.
- if_valid  out  1  if_pc/if_instr hold a valid instruction.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  32  presented instruction.

Behaviour:
- Reset (rst=0, asynchronous): pc_q=RESET_PC, FIFO empty, outstanding=0, drop_cnt=0. Outputs: imem_req_valid=0, if_valid=0, if_pc=0, if_instr=32'h00000013 (NOP).
- Issue rule: imem_req_valid=1 iff rst is deasserted, redirect_valid=0, outstanding<MAX_OUTSTANDING, and fifo_count+outstanding-drop_cnt<DEPTH (credit ensures no response overflows the FIFO).
- Request acceptance: when imem_req_valid && imem_req_ready, pc_q += 4, outstanding += 1, and a pc entry is pushed into the in-flight pc queue (MAX_OUTSTANDING deep).
- Response handling: on imem_rsp_valid, outstanding -= 1 and the in-flight pc queue pops.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Otherwise {popped pc, imem_rsp_data} is pushed into the FIFO.
  - Minimum latency is 1 cycle from acceptance to FIFO push; an instruction accepted at edge N can be presented after edge N+1.
- Output: if_valid = !fifo_empty, with if_pc and if_instr taken from the FIFO head. When if_valid=0, if_instr=NOP and if_pc=0.
- Pop: the FIFO head pops when if_valid && !stall && !redirect_valid.
- Stall: the head and all outputs hold stable. Fetch continues until credits are exhausted, then imem_req_valid deasserts.
- Redirect (highest priority), applied in the same cycle:
  - FIFO is flushed.
  - pc_q = {redirect_pc[XLEN-1:2], 2'b00}; bits [1:0] are ignored.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle. if_valid=0 in the following cycle, which is a guaranteed bubble.
  - Redirect while stall=1 still flushes.
- Simultaneous events:
  - Push and pop in the same cycle when full is legal; the credit rule prevents a push into a full FIFO.
  - Request acceptance and response in the same cycle leave outstanding unchanged.
- Wrap-around: pc_q wraps modulo 2^XLEN. FIFO pointers wrap modulo DEPTH, using an extra bit to distinguish full from empty.
- Reset mid-operation: all state clears immediately. Responses in flight at reset are the memory model's responsibility; the memory is reset together with this block.
- Assertions (verification):
  - Never push into a full FIFO.
  - outstanding ≤ MAX_OUTSTANDING.
  - drop_cnt ≤ outstanding.
  - imem_addr is stable while imem_req_valid && !imem_req_ready.

Decomposition:
- Package fetch_pkg:
  - XLEN_DEF, INSTR_W=32, NOP_INSTR=32'h00000013.
  - typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr}.
  - PC_STEP=4.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, full and empty, reused for both the instruction FIFO and the in-flight pc queue.
- fetch_unit contains the PC register, the credit/outstanding/drop counters, and the issue logic.

Test Plan:
- Reset then release with a 1-cycle, always-ready memory -> first imem_addr=0; if_pc sequence 0,4,8,12 with if_valid=1 every cycle from the third cycle after release.
- stall=1 held for 10 cycles, latency 1 -> imem_req_valid drops once 4 entries are buffered; if_pc stays 0x8 throughout; on release the sequence continues 0x8,0xC,... with no loss or duplication.
- Latency-3 memory with 2 outstanding, redirect_pc=0x100 -> both stale responses are discarded (drop_cnt 2→0); next if_pc=0x100; no stale PC ever has if_valid=1.
- Redirect in the same cycle as a response -> that response is dropped; drop_cnt=outstanding−1; the bubble cycle shows if_valid=0.
- redirect_pc=0x203 -> imem_addr=0x80 (word address of 0x200); if_pc=0x200.
- Assert rst=0 mid-stream with 3 entries buffered -> if_valid=0 and if_instr=NOP asynchronously; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front-end.
//   XLEN_DEF      : default PC / address width
//   INSTR_W       : instruction word width
//   NOP_INSTR     : word presented to decode when nothing valid is held
//   PC_STEP       : sequential fetch increment in bytes
//   fetch_entry_t : {pc, instr} pair carried by the fetch FIFOs
package fetch_pkg;

  localparam int XLEN_DEF = 64;
  localparam int INSTR_W  = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [INSTR_W-1:0]  instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t. Used both as the instruction buffer in
// front of decode and as the queue of PCs whose memory requests are in flight.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i          : write push_data_i at the tail this cycle
//   push_data_i     : entry to write
//   pop_i           : drop the head this cycle (ignored while empty)
//   flush_i         : discard all entries; wins over push and pop
//   head_o          : oldest entry (don't-care while empty)
//   count_o         : number of stored entries
//   full_o, empty_o : occupancy flags
// DEPTH must be a power of two >= 2. Pointers carry one extra wrap bit so that
// full (same index, different wrap) is distinguishable from empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [AW:0]  count_o,
  output logic         full_o,
  output logic         empty_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_i)            wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i && !empty_o) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  // When full, a simultaneous push and pop write the slot being read, which
  // is safe because the head is consumed from the old contents this cycle.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end feeding the IF/ID register.
//   clk, rst            : clock, asynchronous active-low reset
//   imem_req_valid/ready: word request handshake to instruction memory
//   imem_addr           : word address {2'b00, pc[XLEN-1:2]}
//   imem_rsp_valid/data : in-order response (no back-pressure)
//   stall               : decode cannot take the presented instruction
//   redirect_valid/pc   : taken branch from ID; flushes and restarts fetch
//   if_valid/pc/instr   : instruction presented to decode (0 / NOP when idle)
//
// Handshakes: a request transfers on a cycle where imem_req_valid and
// imem_req_ready are both high; while valid is high and ready low the address
// is held. Responses are accepted unconditionally in request order. An
// instruction is consumed by decode on a cycle with if_valid && !stall &&
// !redirect_valid.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEF,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [XLEN-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr
);

  localparam int FAW = $clog2(DEPTH);
  localparam int QAW = $clog2(MAX_OUTSTANDING);
  localparam int OW  = QAW + 1;
  localparam int CW  = FAW + 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [OW-1:0]   out_q, out_d;    // requests accepted, response not yet seen
  logic [OW-1:0]   drop_q, drop_d;  // of those, how many are wrong-path

  logic            req_fire;
  logic            rsp_keep;
  logic            fifo_pop;
  logic [CW-1:0]   credit_used;
  logic            has_credit;
  logic            below_max;

  fetch_entry_t    infl_push_entry, infl_head, rsp_entry, fifo_head;
  logic [QAW:0]    infl_count;
  logic            infl_full, infl_empty;
  logic [FAW:0]    fifo_count;
  logic            fifo_full, fifo_empty;

  logic            unused_pc_lsb;
  assign unused_pc_lsb = ^{redirect_pc[1:0], pc_q[1:0]};

  // Every response that will be kept needs a FIFO slot reserved at issue
  // time; responses already marked for dropping do not consume a slot.
  assign credit_used = CW'(fifo_count) + CW'(out_q) - CW'(drop_q);
  assign has_credit  = credit_used < CW'(DEPTH);
  assign below_max   = out_q < OW'(MAX_OUTSTANDING);

  assign imem_req_valid = rst && !redirect_valid && below_max && has_credit;
  assign imem_addr      = {2'b00, pc_q[XLEN-1:2]};
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response in the redirect cycle belongs to the old path and is dropped.
  assign rsp_keep = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign fifo_pop = if_valid && !stall && !redirect_valid;

  always_comb begin
    infl_push_entry       = '0;
    infl_push_entry.pc    = pc_q;
    infl_push_entry.instr = NOP_INSTR;
    rsp_entry             = infl_head;
    rsp_entry.instr       = imem_rsp_data;
  end

  always_comb begin
    pc_d   = pc_q;
    out_d  = out_q;
    drop_d = drop_q;
    if (req_fire) pc_d = pc_q + XLEN'(PC_STEP);
    if (req_fire && !imem_rsp_valid)      out_d = out_q + 1'b1;
    else if (!req_fire && imem_rsp_valid) out_d = out_q - 1'b1;
    if (redirect_valid) begin
      // No request fires in a redirect cycle, so every outstanding response
      // (minus one arriving right now) is wrong-path.
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = imem_rsp_valid ? out_q - 1'b1 : out_q;
    end else if (imem_rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(MAX_OUTSTANDING)) u_inflight (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (req_fire),
    .push_data_i (infl_push_entry),
    .pop_i       (imem_rsp_valid),
    .flush_i     (1'b0),
    .head_o      (infl_head),
    .count_o     (infl_count),
    .full_o      (infl_full),
    .empty_o     (infl_empty)
  );

  fetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (rsp_keep),
    .push_data_i (rsp_entry),
    .pop_i       (fifo_pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign if_valid = !fifo_empty;
  assign if_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign if_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;

  a_out_max: assert property (@(posedge clk) disable iff (!rst)
    out_q <= OW'(MAX_OUTSTANDING));
  a_drop_le_out: assert property (@(posedge clk) disable iff (!rst)
    drop_q <= out_q);
  a_addr_stable: assert property (@(posedge clk) disable iff (!rst)
    imem_req_valid && !imem_req_ready |=> $stable(imem_addr));
  a_infl_tracks_out: assert property (@(posedge clk) disable iff (!rst)
    infl_count == out_q);
  a_rsp_has_pc: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> !infl_empty);
  a_infl_room: assert property (@(posedge clk) disable iff (!rst)
    req_fire |-> !infl_full);
  a_ibuf_room: assert property (@(posedge clk) disable iff (!rst)
    rsp_keep |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. The reference model is the architectural
// instruction stream: decode must see pc, pc+4, ... from the last reset or
// redirect target, each with the word the memory holds at that address.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall, redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(
    .XLEN(64), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] waddr);
    return (waddr[31:0] * 32'h9E37_79B1) ^ waddr[63:32] ^ 32'h0BAD_F00D;
  endfunction

  // ---------------- memory model ----------------
  typedef struct {
    logic [63:0] waddr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  int          lat_min = 1;
  int          lat_max = 1;
  int          ready_pct = 100;
  int          last_due = 0;
  logic [63:0] exp_fetch = RESET_PC;

  initial begin
    int due;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mem_q.delete();
        last_due  = 0;
        exp_fetch = RESET_PC;
      end else begin
        if (imem_rsp_valid) void'(mem_q.pop_front());
        if (redirect_valid) begin
          check("no_req_in_redirect", 64'(imem_req_valid), 64'd0);
          exp_fetch = {redirect_pc[63:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
          check("fetch_addr", imem_addr, {2'b00, exp_fetch[63:2]});
          exp_fetch = exp_fetch + 64'd4;
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_q.push_back('{imem_addr, due});
        end
      end
      @(posedge clk);
      #1;
      if (rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word_of(mem_q[0].waddr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      imem_req_ready = ($urandom_range(100, 1) <= ready_pct);
    end
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // PCs decode must see next, in order
  logic [63:0] stream_pc;
  int          consumed = 0;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(stream_pc);
      stream_pc = stream_pc + 64'd4;
    end
  endtask

  // Monitor: compares whatever decode is shown against the expected stream.
  initial begin
    bit bubble = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        bubble = 1'b0;
        check("reset_if_valid", 64'(if_valid), 64'd0);
        check("reset_if_pc", if_pc, 64'd0);
        check("reset_if_instr", 64'(if_instr), 64'(NOP_INSTR));
        check("reset_req_valid", 64'(imem_req_valid), 64'd0);
      end else begin
        if (bubble) begin
          check("bubble_after_redirect", 64'(if_valid), 64'd0);
          bubble = 1'b0;
        end
        if (redirect_valid) begin
          bubble = 1'b1;
        end else if (if_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: pc 0x%0h with empty expected queue", if_pc);
          end else begin
            check("if_pc", if_pc, exp_q[0]);
            check("if_instr", 64'(if_instr), 64'(word_of(exp_q[0] >> 2)));
            if (!stall) begin
              void'(exp_q.pop_front());
              consumed++;
            end
          end
        end else begin
          check("idle_if_pc", if_pc, 64'd0);
          check("idle_if_instr", 64'(if_instr), 64'(NOP_INSTR));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input bit s, input bit r, input logic [63:0] tgt);
    @(posedge clk);
    #1;
    stall          = s;
    redirect_valid = r;
    redirect_pc    = tgt;
    if (r) begin
      exp_q.delete();
      stream_pc = {tgt[63:2], 2'b00};
    end
    refill();
  endtask

  task automatic expect_next_pc(input string name, input logic [63:0] pc);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      drive(1'b0, 1'b0, 64'd0);
      @(negedge clk);
      if (if_valid) begin
        seen = 1'b1;
        check(name, if_pc, pc);
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no valid output within 30 cycles, expected pc 0x%0h", name, pc);
    end
  endtask

  initial begin
    int c_start;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stream_pc      = RESET_PC;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);

    // Release with a 1-cycle always-ready memory: full rate from 3rd cycle.
    @(posedge clk);
    #2;
    rst       = 1'b1;
    stream_pc = RESET_PC;
    exp_q.delete();
    refill();
    drive(1'b0, 1'b0, 64'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 64'd0);
      @(negedge clk);
      check("full_rate_valid", 64'(if_valid), 64'd1);
    end

    // Hold stall: buffer fills, requests stop, head holds.
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 64'd0);
    @(negedge clk);
    check("req_stops_when_buffered", 64'(imem_req_valid), 64'd0);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 64'd0);

    // Latency 3, two in flight, redirect discards both stale responses.
    lat_min = 3;
    lat_max = 3;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b1, 64'h100);
    expect_next_pc("first_after_redirect_lat3", 64'h100);
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 64'd0);

    // Latency 1: a response arrives in the redirect cycle itself.
    lat_min = 1;
    lat_max = 1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 64'd0);
    drive(1'b0, 1'b1, 64'h400);
    expect_next_pc("first_after_redirect_rsp", 64'h400);

    // Unaligned target: low bits ignored.
    drive(1'b0, 1'b1, 64'h203);
    drive(1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("redirect_word_addr", imem_addr, 64'h80);
    expect_next_pc("unaligned_redirect_pc", 64'h200);

    // Redirect while stalled still flushes.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 64'd0);
    drive(1'b1, 1'b1, 64'h7000);
    expect_next_pc("redirect_under_stall", 64'h7000);

    // PC wrap-around.
    drive(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 64'd0);

    // Randomised traffic.
    lat_min   = 1;
    lat_max   = 4;
    ready_pct = 70;
    c_start   = consumed;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(99, 0) < 4)
        drive($urandom_range(99, 0) < 25, 1'b1, {$urandom, $urandom});
      else
        drive($urandom_range(99, 0) < 25, 1'b0, 64'd0);
    end
    check("random_progress", 64'(consumed - c_start > 100), 64'd1);

    // Reset mid-stream with entries buffered.
    lat_min   = 1;
    lat_max   = 1;
    ready_pct = 100;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("async_reset_if_valid", 64'(if_valid), 64'd0);
    check("async_reset_if_instr", 64'(if_instr), 64'(NOP_INSTR));
    check("async_reset_if_pc", if_pc, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst       = 1'b1;
    stall     = 1'b0;
    stream_pc = RESET_PC;
    refill();
    expect_next_pc("restart_at_reset_pc", RESET_PC);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
